sync_fifo_flex: RTL

Parametrised synchronous FIFO, the general-purpose successor to the fixed power-of-two buffer used across bus bridges, the display pipeline and UART/SPI data paths. It supports arbitrary depth, a selectable read mode (first-word-fallthrough or registered-output) and registered almost-full/almost-empty thresholds. Illegal operations are always gated off. An optional build feature adds sticky error flags.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/sync_fifo_flex_if.sv | 28 ++
 rtl/fifo_ptr_wrap.sv | 32 +++
 rtl/sync_fifo_flex.sv | 110 +++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode selectors and width helpers.
package fifo_pkg;

  localparam int FIFO_MODE_REGOUT = 0;
  localparam int FIFO_MODE_FWFT   = 1;

  // Level must represent 0..depth inclusive, hence depth+1 states.
  function automatic int fifo_lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int fifo_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo_flex_if.sv
// Push/pop/status bundle for sync_fifo_flex; master = producer/consumer side, slave = FIFO side.
interface sync_fifo_flex_if #(
  parameter int WIDTH   = 32,
  parameter int W_LEVEL = 3
);
  logic [WIDTH-1:0]   w_data;
  logic               w_en;
  logic               r_en;
  logic               err_clr;
  logic [WIDTH-1:0]   r_data;
  logic               full;
  logic               empty;
  logic               almost_full;
  logic               almost_empty;
  logic [W_LEVEL-1:0] level;
  logic               overflow;
  logic               underflow;

  modport master (
    output w_data, w_en, r_en, err_clr,
    input  r_data, full, empty, almost_full, almost_empty, level, overflow, underflow
  );

  modport slave (
    input  w_data, w_en, r_en, err_clr,
    output r_data, full, empty, almost_full, almost_empty, level, overflow, underflow
  );
endinterface

// File: rtl/fifo_ptr_wrap.sv
// Modulo-DEPTH pointer: advances on inc, wraps DEPTH-1 -> 0 explicitly (no power-of-two assumption).
// One-cycle update latency; no backpressure of its own.
module fifo_ptr_wrap
  import fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = fifo_ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) begin
      if (ptr_q == PW'(DEPTH - 1)) ptr_d = '0;
      else                         ptr_d = ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/sync_fifo_flex.sv
// Arbitrary-depth sync FIFO, FWFT or registered-output read; sticky errors under SYNC_FIFO_FLEX_ERR_FLAGS_EN.
// Write->read 1 cycle (FWFT) / r_data 1 cycle after r_en (REGOUT); push when full (no pop) and pop when empty are dropped.
module sync_fifo_flex
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int FWFT     = 1,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  parameter int W_LEVEL  = fifo_lvl_w(DEPTH)
) (
  input logic              clk,
  input logic              rst_n,
  sync_fifo_flex_if.slave  bus
);

  localparam int PW = fifo_ptr_w(DEPTH);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic [W_LEVEL-1:0] level_q, level_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               af_q, af_d;
  logic               ae_q, ae_d;
  logic [PW-1:0]      w_ptr, r_ptr;
  logic               push, pop;

  assign pop  = bus.r_en && !empty_q;
  assign push = bus.w_en && (!full_q || pop);

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_w_ptr (.clk(clk), .rst_n(rst_n), .inc(push), .ptr(w_ptr));
  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_r_ptr (.clk(clk), .rst_n(rst_n), .inc(pop),  .ptr(r_ptr));

  // Flags derive from the next level so they always agree with level_q.
  always_comb begin
    level_d = level_q + W_LEVEL'(push) - W_LEVEL'(pop);
    full_d  = (level_d == W_LEVEL'(DEPTH));
    empty_d = (level_d == '0);
    af_d    = (int'(level_d) >= AF_LEVEL);
    ae_d    = (int'(level_d) <= AE_LEVEL);
    rdata_d = pop ? mem_q[r_ptr] : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= (AF_LEVEL == 0);
      ae_q    <= (AE_LEVEL >= 0);
      rdata_q <= '0;
    end else begin
      level_q <= level_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem_q[w_ptr] <= bus.w_data;
  end

`ifdef SYNC_FIFO_FLEX_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (bus.err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (bus.w_en && full_q && !pop) ovf_d = 1'b1;
    if (bus.r_en && empty_q)        udf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.overflow   = 1'b0;
  assign bus.underflow  = 1'b0;
`endif

  assign bus.r_data       = (FWFT == FIFO_MODE_FWFT) ? mem_q[r_ptr] : rdata_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.level        = level_q;

endmodule
